stage_m: RTL
============

Name: stage_m

Overview:
- Memory stage of the combined RISC-V/ARM five-stage pipeline. Sits between execute and stage_w.
- Holds the E->M pipeline register and drives a req/ready/rvalid data-memory port.
- Formats stores into byte lanes and sign/zero-extends loads into ReadDataW, which arrives aligned with the instruction in W.
- Raises StallM while a memory access is outstanding and presents a bubble to W during stalls.

Parameters:
- (none; data width fixed at 32, byte lanes fixed at 4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ALUResultE  in  32  address / ALU result
- WriteDataE  in  32  store data (unaligned, LSB-justified)
- PCPlus4E  in  32  RV link value
- RdE  in  5  destination register
- RegWriteE  in  1  register write enable
- ResultSrcE  in  2  result select (00 ALU, 01 load, 10 PC+4)
- MemWriteE  in  1  store
- MemReadE  in  1  load
- SizeE  in  3  funct3-style code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- armE  in  1  ARM instruction flag
- PCSrcE  in  1  ARM PC write
- ALUResultM  out  32  registered
- PCPlus4M  out  32  registered
- RdM  out  5  registered
- RegWriteM  out  1  registered value AND NOT StallM AND NOT MisalignedM
- ResultSrcM  out  2  registered
- armM  out  1  registered
- PCSrcM  out  1  registered value AND NOT StallM
- ReadDataW  out  32  formatted load data, registered, valid in W
- StallM  out  1  hold E and M; upstream must not advance
- MisalignedM  out  1  current M access is misaligned
- mem_req  out  1  access request
- mem_we  out  1  write
- mem_addr  out  32  word-aligned address (ALUResultM[31:2], 2'b00)
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- Reset (sync, rst=1 at posedge): all M registers and ReadDataW clear to 0; FSM enters IDLE. Outputs are therefore 0, and StallM=0.
- M register loads E inputs each posedge when StallM=0 and holds when StallM=1.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0, and MemRead|MemWrite set.
  - MisalignedM=1; no mem_req issued; no stall; RegWriteM suppressed.
- Store formatting:
  - B: wdata = {4{WriteData[7:0]}}, be = 1<<addr[1:0].
  - H: wdata = {2{WriteData[15:0]}}, be = addr[1] ? 1100 : 0011.
  - W: wdata = WriteData, be = 1111.
  - Loads: be = 1111.
- FSM:
  - IDLE: mem_req = (MemReadM|MemWriteM) & ~MisalignedM.
    - No access -> stay IDLE, StallM=0.
    - Access and mem_ready=0 -> REQ, StallM=1.
    - Store accepted -> stay IDLE, StallM=0 (stores complete on acceptance).
    - Load accepted -> RESP, StallM=1.
  - REQ: mem_req held with stable addr/wdata/be/we until mem_ready.
    - On acceptance: store -> IDLE with StallM=0 that cycle; load -> RESP, StallM stays 1.
  - RESP: mem_req=0. StallM=1 until mem_rvalid.
    - In the cycle with mem_rvalid=1: StallM=0, formatted data latched into ReadDataW at that posedge, FSM -> IDLE.
    - The instruction enters W at the same edge.
- mem_rvalid is never expected in the acceptance cycle. Minimum load latency is 1 stall cycle; stores with mem_ready=1 have 0 stall cycles.
- Load extension uses registered SizeM and addr[1:0]:
  - B/BU: select byte addr[1:0], sign/zero-extend.
  - H/HU: select half addr[1], sign/zero-extend.
  - W: pass through.
- ReadDataW holds its value when no load completes.
- mem_rvalid outside RESP is ignored.
- Reset mid-access (REQ or RESP): FSM -> IDLE, request dropped, any later rvalid ignored.
- The M register has no flush input; hazard logic inserts bubbles at E.

Test Plan:
- Reset: assert rst 2 cycles during RESP -> next cycle StallM=0, mem_req=0, ReadDataW=0, RegWriteM=0.
- SW to 0x100, data 0xDEADBEEF, mem_ready=1 -> mem_req=1, we=1, be=1111, addr=0x100, StallM never asserted.
- SB 0x5A to 0x103, mem_ready low 3 cycles -> StallM=1 for 3 cycles, wdata=0x5A5A5A5A, be=1000, signals stable; RegWriteM=0 while stalled.
- LB from 0x102, rdata=0x11802233, rvalid 2 cycles after accept -> StallM=1 for 2 cycles, then ReadDataW=0xFFFFFF80. LBU from the same address -> 0x00000080.
- LH from 0x101 -> MisalignedM=1, mem_req=0, StallM=0, RegWriteM=0. LW from 0x104 on the next cycle proceeds normally.
- Back-to-back LW 0x0 (rdata 0x1), LW 0x4 (rdata 0x2), 1-cycle rvalid -> ReadDataW shows 0x1 then 0x2, each aligned with RdW of its load in stage_w.

Source files
------------

// File: rtl/stage_m_if.sv
// Data-memory port of the memory stage: req/ready request channel plus rvalid response.
interface stage_m_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/stage_m.sv
// Memory stage: E->M pipeline register, store lane formatting, load extension into
// ReadDataW, and the IDLE/REQ/RESP handshake FSM that drives StallM.
module stage_m (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic        MemWriteE,
  input  logic        MemReadE,
  input  logic [2:0]  SizeE,
  input  logic        armE,
  input  logic        PCSrcE,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic        armM,
  output logic        PCSrcM,
  output logic [31:0] ReadDataW,
  output logic        StallM,
  output logic        MisalignedM,
  stage_m_if.master   mem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;

  logic [31:0] alu_q, wdata_q, pc4_q;
  logic [4:0]  rd_q;
  logic        regwrite_q, memwrite_q, memread_q, arm_q, pcsrc_q;
  logic [1:0]  rsrc_q;
  logic [2:0]  size_q;
  logic        misaligned, access;
  logic [31:0] lane, load_fmt;

  always_comb begin
    misaligned = 1'b0;
    if (memread_q | memwrite_q) begin
      case (size_q[1:0])
        2'b01:   misaligned = alu_q[0];
        2'b10:   misaligned = (alu_q[1:0] != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
    access = (memread_q | memwrite_q) & ~misaligned;
  end

  // A store completes on acceptance; a load always waits at least one cycle for rvalid.
  always_comb begin
    StallM = 1'b0;
    case (state)
      IDLE:    StallM = access & (~mem.mem_ready | memread_q);
      REQ:     StallM = ~mem.mem_ready | memread_q;
      RESP:    StallM = ~mem.mem_rvalid;
      default: StallM = 1'b0;
    endcase
  end

  always_comb begin
    mem.mem_req   = access & (state != RESP);
    mem.mem_we    = memwrite_q;
    mem.mem_addr  = {alu_q[31:2], 2'b00};
    mem.mem_wdata = wdata_q;
    mem.mem_be    = 4'b1111;
    if (memwrite_q) begin
      case (size_q[1:0])
        2'b00: begin
          mem.mem_wdata = {4{wdata_q[7:0]}};
          mem.mem_be    = 4'b0001 << alu_q[1:0];
        end
        2'b01: begin
          mem.mem_wdata = {2{wdata_q[15:0]}};
          mem.mem_be    = alu_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem.mem_wdata = wdata_q;
          mem.mem_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    lane     = mem.mem_rdata >> {alu_q[1:0], 3'b000};
    load_fmt = mem.mem_rdata;
    case (size_q[1:0])
      2'b00:   load_fmt = {{24{~size_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   load_fmt = {{16{~size_q[2] & lane[15]}}, lane[15:0]};
      default: load_fmt = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_q      <= '0;
      wdata_q    <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      rsrc_q     <= '0;
      memwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      size_q     <= '0;
      arm_q      <= 1'b0;
      pcsrc_q    <= 1'b0;
      ReadDataW  <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          if (mem.mem_ready) state <= memread_q ? RESP : IDLE;
          else               state <= REQ;
        end
        REQ: if (mem.mem_ready) state <= memread_q ? RESP : IDLE;
        RESP: if (mem.mem_rvalid) begin
          state     <= IDLE;
          ReadDataW <= load_fmt;
        end
        default: state <= IDLE;
      endcase
      if (!StallM) begin
        alu_q      <= ALUResultE;
        wdata_q    <= WriteDataE;
        pc4_q      <= PCPlus4E;
        rd_q       <= RdE;
        regwrite_q <= RegWriteE;
        rsrc_q     <= ResultSrcE;
        memwrite_q <= MemWriteE;
        memread_q  <= MemReadE;
        size_q     <= SizeE;
        arm_q      <= armE;
        pcsrc_q    <= PCSrcE;
      end
    end
  end

  assign ALUResultM  = alu_q;
  assign PCPlus4M    = pc4_q;
  assign RdM         = rd_q;
  assign ResultSrcM  = rsrc_q;
  assign armM        = arm_q;
  assign MisalignedM = misaligned;
  assign RegWriteM   = regwrite_q & ~StallM & ~misaligned;
  assign PCSrcM      = pcsrc_q & ~StallM;

endmodule
